// File: rtl/lamp_sequencer_if.sv
// -----------------------------------------------------------------------------
// lamp_sequencer_if
//   Control / status bundle between a controller (master) and the running-light
//   sequencer (slave). Clock and reset stay plain ports on the sequencer.
//
//   Parameters
//     N_LAMPS  number of lamps in the bank (2..32)
//     CNT_W    width of the repeat count and pass index
//
//   Signals (direction as seen by the sequencer, modport slave)
//     start     in   level; rising edge starts / retriggers a run
//     abort     in   synchronous stop, lamps blank, no done
//     mode      in   pattern select, sampled at the start edge
//     repeat_n  in   number of passes, sampled at the start edge (0 -> 1)
//     lump      out  lamp drive, bit N_LAMPS-1 is the leftmost lamp
//     busy      out  high while a run is in progress
//     done      out  one-cycle pulse after the last pattern of the last pass
//     outreset  out  reset indicator
//     pass_idx  out  current pass, 0-based, 0 when idle
// -----------------------------------------------------------------------------
interface lamp_sequencer_if #(
  parameter int N_LAMPS = 8,
  parameter int CNT_W   = 4
);
  logic               start;
  logic               abort;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   repeat_n;
  logic [N_LAMPS-1:0] lump;
  logic               busy;
  logic               done;
  logic               outreset;
  logic [CNT_W-1:0]   pass_idx;

  // Controller side: drives the commands, observes the status.
  modport master (
    output start,
    output abort,
    output mode,
    output repeat_n,
    input  lump,
    input  busy,
    input  done,
    input  outreset,
    input  pass_idx
  );

  // Sequencer side.
  modport slave (
    input  start,
    input  abort,
    input  mode,
    input  repeat_n,
    output lump,
    output busy,
    output done,
    output outreset,
    output pass_idx
  );
endinterface

// File: rtl/lamp_sequencer.sv
// -----------------------------------------------------------------------------
// lamp_sequencer
//   Parametrised running-light sequencer for the slow (500 ms) clock domain.
//   Drives an N-lamp bank through one of four patterns for a programmable
//   number of passes, then pulses done for one cycle.
//
//   Patterns (N = 8 shown):
//     mode 00  sweep right  80 40 .. 01                  L = N
//     mode 01  sweep left   01 02 .. 80                  L = N
//     mode 10  bounce       80 .. 01 02 .. 40            L = 2N-2
//     mode 11  fill bar     80 C0 .. FF                  L = N
//
//   Ports
//     clk_500ms  in   sequencer clock (divided clock)
//     reset2     in   asynchronous, active-high reset
//     bus        slave modport of lamp_sequencer_if (start, abort, mode,
//                repeat_n in; lump, busy, done, outreset, pass_idx out)
//
//   Every output comes straight from a register; the inputs only reach the
//   next-state logic.
// -----------------------------------------------------------------------------
module lamp_sequencer #(
  parameter int N_LAMPS = 8,
  parameter int CNT_W   = 4
) (
  input  logic            clk_500ms,
  input  logic            reset2,
  lamp_sequencer_if.slave bus
);

  // Step counter must hold up to 2N-3 (bounce); clog2(2N) covers that.
  localparam int SW = $clog2(2 * N_LAMPS);

  localparam logic [SW-1:0]    LAST_LAMP   = SW'(N_LAMPS - 1);
  localparam logic [SW-1:0]    LAST_BOUNCE = SW'(2 * N_LAMPS - 3);
  localparam logic [CNT_W-1:0] ONE_PASS    = CNT_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [SW-1:0]      r_step;
  logic [CNT_W-1:0]   r_pass;
  logic [CNT_W-1:0]   r_rep;
  logic [1:0]         r_mode;
  logic [N_LAMPS-1:0] r_lump;
  logic               r_busy;
  logic               r_done;
  logic               r_start_q;
  logic               r_outreset;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  state_t             w_state_next;
  logic [SW-1:0]      w_step_next;
  logic [CNT_W-1:0]   w_pass_next;
  logic [CNT_W-1:0]   w_rep_next;
  logic [1:0]         w_mode_next;
  logic [N_LAMPS-1:0] w_lump_next;
  logic               w_busy_next;
  logic               w_done_next;

  logic               w_st_edge;
  logic [CNT_W-1:0]   w_rep_in;
  logic [SW-1:0]      w_last_step;
  logic [CNT_W-1:0]   w_last_pass;

  // ---------------------------------------------------------------------------
  // Pattern generator: lamp word for a given mode and step.
  // ---------------------------------------------------------------------------
  function automatic logic [N_LAMPS-1:0] f_pattern(
    input logic [1:0]    m,
    input logic [SW-1:0] s
  );
    logic [N_LAMPS-1:0] one_hot;
    logic [N_LAMPS-1:0] all_ones;
    logic [N_LAMPS-1:0] p;
    one_hot  = {{(N_LAMPS-1){1'b0}}, 1'b1};
    all_ones = {N_LAMPS{1'b1}};
    p        = '0;
    case (m)
      2'b00: p = one_hot << (LAST_LAMP - s);
      2'b01: p = one_hot << s;
      2'b10: begin
        // First half walks right from the MSB; second half walks back left,
        // starting one lamp above the LSB so the end lamps are not repeated.
        if (s <= LAST_LAMP) begin
          p = one_hot << (LAST_LAMP - s);
        end else begin
          p = one_hot << (s - LAST_LAMP);
        end
      end
      default: begin
        // Fill bar: top (s+1) lamps lit. s+1 never exceeds N here.
        p = ~(all_ones >> (s + SW'(1)));
      end
    endcase
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  assign w_st_edge   = bus.start & ~r_start_q;
  assign w_rep_in    = (bus.repeat_n == '0) ? ONE_PASS : bus.repeat_n;
  assign w_last_step = (r_mode == 2'b10) ? LAST_BOUNCE : LAST_LAMP;
  // r_rep is never 0, so this cannot underflow.
  assign w_last_pass = r_rep - ONE_PASS;

  // ---------------------------------------------------------------------------
  // FSM state register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_500ms or posedge reset2) begin
    if (reset2) begin
      r_state    <= S_IDLE;
      r_step     <= '0;
      r_pass     <= '0;
      r_rep      <= ONE_PASS;
      r_mode     <= 2'b00;
      r_lump     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      // Held high so a start level present through reset is not an edge.
      r_start_q  <= 1'b1;
      r_outreset <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_step     <= w_step_next;
      r_pass     <= w_pass_next;
      r_rep      <= w_rep_next;
      r_mode     <= w_mode_next;
      r_lump     <= w_lump_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_start_q  <= bus.start;
      // Indicator drops on the first clock after reset is released.
      r_outreset <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state / output logic
  // Priority: abort > start edge (from any state) > normal stepping.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_step_next  = r_step;
    w_pass_next  = r_pass;
    w_rep_next   = r_rep;
    w_mode_next  = r_mode;
    w_lump_next  = r_lump;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;

    if (bus.abort) begin
      w_state_next = S_IDLE;
      w_step_next  = '0;
      w_pass_next  = '0;
      w_lump_next  = '0;
      w_busy_next  = 1'b0;
    end else if (w_st_edge) begin
      // Start or retrigger: resample mode / repeat count, show step 0 now.
      w_state_next = S_RUN;
      w_mode_next  = bus.mode;
      w_rep_next   = w_rep_in;
      w_step_next  = '0;
      w_pass_next  = '0;
      w_lump_next  = f_pattern(bus.mode, '0);
      w_busy_next  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_step_next = '0;
          w_pass_next = '0;
          w_lump_next = '0;
          w_busy_next = 1'b0;
        end
        S_RUN: begin
          if (r_step < w_last_step) begin
            w_step_next = r_step + SW'(1);
            w_lump_next = f_pattern(r_mode, r_step + SW'(1));
          end else if (r_pass < w_last_pass) begin
            w_pass_next = r_pass + ONE_PASS;
            w_step_next = '0;
            w_lump_next = f_pattern(r_mode, '0);
          end else begin
            w_state_next = S_IDLE;
            w_step_next  = '0;
            w_pass_next  = '0;
            w_lump_next  = '0;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_lump_next  = '0;
          w_busy_next  = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.lump     = r_lump;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.outreset = r_outreset;
  assign bus.pass_idx = r_pass;

endmodule

// File: doc/lamp_sequencer.md
# lamp_sequencer

Parametrised running-light sequencer for the slow (500 ms) clock domain. It drives an N-lamp bank through one of four selectable patterns for a programmable number of passes, then pulses `done`. It is the generalised successor to the fixed 8-lamp single-sweep block and sits downstream of the clock divider, in the same position in the top level.

## Interface
- `N_LAMPS`, 8, number of lamps; legal range 2..32.
- `CNT_W`, 4, width of the repeat-count input and the pass counter.
- `clk_500ms`  in  1  sequencer clock (divided clock).
- `reset2`  in  1  reset, asynchronous, active-high.
- `start`  in  1  level input; a rising edge (sampled on `clk_500ms`) starts or retriggers a run.
- `abort`  in  1  synchronous stop; the lamps blank with no `done` pulse.
- `mode`  in  2  pattern select, sampled at the start edge.
- `repeat_n`  in  CNT_W  number of passes, sampled at the start edge; 0 is treated as 1.
- `lump`  out  N_LAMPS  lamp drive; bit N_LAMPS-1 is the leftmost lamp.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse after the last pattern of the last pass.
- `outreset`  out  1  reset indicator.
- `pass_idx`  out  CNT_W  current pass, 0-based; holds 0 when idle.

## Operation
- Start-edge detect: `start_q` is registered. `st_edge = start & ~start_q`. `start_q` resets to 1, so a `start` held high through reset does not trigger.
- States: IDLE and RUN.
- IDLE -> RUN on `st_edge`:
  - latch `mode_r`, `rep_r = (repeat_n==0)?1:repeat_n`;
  - step=0, pass=0;
  - `lump` = pattern(step 0) on the same edge;
  - `busy`=1.
- Patterns (shown for N=8):
  - mode 00, sweep right: 1000_0000 -> 0100_0000 -> … -> 0000_0001. Pass length L=N.
  - mode 01, sweep left: 0000_0001 -> … -> 1000_0000. L=N.
  - mode 10, bounce: MSB -> LSB -> back toward MSB, without repeating the end lamps: 1000_0000 … 0000_0001 … 0100_0000. L=2N-2.
  - mode 11, fill bar: 1000_0000 -> 1100_0000 -> … -> 1111_1111. L=N.
- RUN, each edge:
  - if step<L-1: step+1 and update the pattern.
  - else if pass<rep_r-1: pass+1, step=0, pattern(step 0).
  - else: `lump`=0, `busy`=0, `done`=1, go to IDLE.
- Retrigger: `st_edge` in RUN restarts from step 0, pass 0, re-sampling `mode` and `repeat_n`. No `done` pulse is produced.
- Abort: `abort`=1 on an edge forces IDLE, `lump`=0, `busy`=0, `done`=0, `pass_idx`=0. `abort` beats `st_edge` on the same edge.
- `mode`/`repeat_n` changes during RUN are ignored.
- IDLE holds `lump`=0 and `done`=0, except for the single pulse cycle.
- Counter widths:
  - step counter: clog2(2*N_LAMPS);
  - pass counter: CNT_W;
  - no wrap is possible, because the comparisons stop at the limits.

## Timing
- Reset (async, `reset2`=1), all immediately:
  - `lump`=0, `busy`=0, `done`=0, `pass_idx`=0;
  - state IDLE, `start_q`=1;
  - `outreset`=1.
- `outreset` stays 1 until the first `clk_500ms` rising edge after `reset2` deasserts, then 0.
- Reset mid-run aborts immediately, with no `done`.
- Latency:
  - the `start` rising edge is seen at clock edge k; pattern(0) is visible after edge k.
  - a run lasts `rep_r*L` cycles with lamps lit;
  - `done`=1 for the cycle after edge k+rep_r*L; it drops on the next edge.
- `st_edge` on the edge that ends the `done` cycle is accepted: `done`->0 and pattern(0) load on that same edge.
- `start` held high produces exactly one run. A new run needs `start` to go low for at least one sampled edge.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

## Test plan
- Reset with `start`=1 held, then release. Required:
  - `lump`=0, `outreset`=1 until the first edge;
  - no run starts until `start` toggles 0->1.
- N=8, mode 00, `repeat_n`=1, start pulse. Required:
  - `lump` walks 0x80, 0x40, … 0x01 over 8 cycles, `busy`=1;
  - then `lump`=0x00, `done`=1 for one cycle, `busy`=0.
- mode 10, `repeat_n`=2. Required:
  - sequence 0x80 … 0x01 … 0x40 (14 cycles), repeated with `pass_idx`=1;
  - `done` after 28 lit cycles.
- mode 11, `repeat_n`=0. Required:
  - 0x80, 0xC0, … 0xFF (treated as 1 pass);
  - then 0x00 with `done`=1.
- Retrigger at step 3 of mode 01 with `mode` changed to 00. Required:
  - next pattern is 0x80, `pass_idx`=0;
  - no `done` is produced before the new run completes.
- Assert `abort` together with a start edge mid-run. Required:
  - `lump`=0, `busy`=0, `done`=0 on that edge;
  - the sequencer stays IDLE.
